// File: rtl/la_clkgate_pkg.sv
// Shared types and elaboration helpers for the clock-gate enable controller.
// Holds the FSM state encoding and the counter-width sanity check.
package la_clkgate_pkg;

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_OFF  = 2'b01;
    localparam logic [1:0] ST_WAKE = 2'b10;

    typedef enum logic [1:0] {
        RUN  = ST_RUN,
        OFF  = ST_OFF,
        WAKE = ST_WAKE
    } state_e;

    // True when a CW-bit counter can reach both terminal counts without wrapping.
    function automatic bit cw_ok(input int cw, input int idle_cycles, input int wake_cycles);
        int max_cnt;
        max_cnt = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return (64'(1) << cw) > 64'(max_cnt);
    endfunction

endpackage

// File: rtl/la_clkgatectrl_if.sv
// Requester / gated-domain handshake bundle for la_clkgatectrl.
// The controller is the slave; the requester and gated domain sit on the master side.
interface la_clkgatectrl_if;

    logic req;
    logic busy;
    logic force_on;
    logic en;
    logic ack;
    logic gated;

    modport master (
        output req,
        output busy,
        output force_on,
        input  en,
        input  ack,
        input  gated
    );

    modport slave (
        input  req,
        input  busy,
        input  force_on,
        output en,
        output ack,
        output gated
    );

endinterface

// File: rtl/la_clkgate_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// done is decoded from the registered count, so it never depends on this cycle's inputs.
module la_clkgate_timer #(
    parameter int CW    = 8,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic nreset,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam logic [CW-1:0] TERM = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: default assigned first so every path through the block drives cnt_d; no latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: non-blocking assignments for all flop updates to avoid simulation ordering races.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (LIMIT > 0) && (cnt_q == TERM);

endmodule

// File: rtl/la_clkgatectrl.sv
// Activity-driven enable generator for an ICG: gates after an idle period, wakes on demand
// and acknowledges once the gated domain has seen WAKE_CYCLES clocks.
module la_clkgatectrl
    import la_clkgate_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CW          = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    la_clkgatectrl_if.slave      cg
);

    localparam bit CW_OK = cw_ok(CW, IDLE_CYCLES, WAKE_CYCLES);

    generate
        if (!CW_OK) begin : g_bad_cw
            $error("la_clkgatectrl: CW too narrow for IDLE_CYCLES/WAKE_CYCLES");
        end
    endgenerate

    state_e state_q;
    state_e state_d;

    logic en_q;
    logic en_d;
    logic ack_q;
    logic ack_d;
    logic gated_q;
    logic gated_d;

    logic idle;
    logic idle_clr;
    logic idle_inc;
    logic idle_done;
    logic wake_clr;
    logic wake_inc;
    logic wake_done;

    assign idle = !cg.req && !cg.busy && !cg.force_on;

    la_clkgate_timer #(
        .CW    (CW),
        .LIMIT (IDLE_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .nreset (nreset),
        .clr    (idle_clr),
        .inc    (idle_inc),
        .done   (idle_done)
    );

    la_clkgate_timer #(
        .CW    (CW),
        .LIMIT (WAKE_CYCLES)
    ) u_wake_timer (
        .clk    (clk),
        .nreset (nreset),
        .clr    (wake_clr),
        .inc    (wake_inc),
        .done   (wake_done)
    );

    always_comb begin
        state_d  = state_q;
        idle_clr = 1'b1;
        idle_inc = 1'b0;
        wake_clr = 1'b1;
        wake_inc = 1'b0;

        unique case (state_q)
            RUN: begin
                // Activity on the expiring edge wins: only a fully idle edge can gate.
                if (idle) begin
                    if ((IDLE_CYCLES != 0) && idle_done) begin
                        state_d = OFF;
                    end else begin
                        idle_clr = 1'b0;
                        idle_inc = 1'b1;
                    end
                end
            end
            OFF: begin
                if (!idle) begin
                    state_d = (WAKE_CYCLES > 0) ? WAKE : RUN;
                end
            end
            WAKE: begin
                if (wake_done) begin
                    state_d = RUN;
                end else begin
                    wake_clr = 1'b0;
                    wake_inc = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are registered copies of the next-state decode, so they track state_q exactly.
    always_comb begin
        en_d    = (state_d != OFF);
        ack_d   = (state_d == RUN);
        gated_d = (state_d == OFF);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= RUN;
            en_q    <= 1'b1;
            ack_q   <= 1'b1;
            gated_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            gated_q <= gated_d;
        end
    end

    assign cg.en    = en_q;
    assign cg.ack   = ack_q;
    assign cg.gated = gated_q;

endmodule
